// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: valid/ready result bus between the ALU, the result stage and writeback.
// Signals: valid/ready handshake, result, zero/overflow/cout flags, op (ALU select), dest tag.
// master drives the payload and valid; slave drives ready.
interface alu_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;
    logic              cout;
    logic [2:0]        op;
    logic [DEST_W-1:0] dest;
    modport master (output valid, result, zero, overflow, cout, op, dest, input ready);
    modport slave  (input valid, result, zero, overflow, cout, op, dest, output ready);
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry skid output stage behind the 32-bit ALU.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   alu (slave)     upstream ALU result bus; ready = skid entry empty (registered)
//   wb  (master)    head entry toward writeback; op is driven 0 (not meaningful downstream)
//   sticky_clr      synchronous clear of sticky_ovf (a same-cycle set wins)
//   sticky_ovf      set by any accepted qualified overflow
//   acc_count       number of accepted inputs, wraps
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    alu,
    alu_result_stage_if.master   wb,
    input  logic                 sticky_clr,
    output logic                 sticky_ovf,
    output logic [CNT_W-1:0]     acc_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
        logic              cout;
        logic [DEST_W-1:0] dest;
    } entry_t;
    state_t state;
    entry_t head, skid, cap;
    logic   vld, rdy, arith, take_in, take_out;
    logic   unused_zero;
    // The raw ALU zero flag is not trusted; zero is recomputed from the result.
    assign unused_zero = alu.zero;
    // Only add/sub/compare-class ops (select 0..2) produce meaningful overflow/carry.
    always_comb begin
        arith    = alu.op <= 3'd2;
        cap      = '{result: alu.result, zero: alu.result == '0, ovf: alu.overflow & arith,
                     cout: alu.cout & arith, dest: alu.dest};
        take_in  = alu.valid & rdy;
        take_out = vld & wb.ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            vld        <= 1'b0;
            rdy        <= 1'b1;
            head       <= '0;
            skid       <= '0;
            sticky_ovf <= 1'b0;
            acc_count  <= '0;
        end else begin
            acc_count  <= acc_count + CNT_W'(take_in);
            sticky_ovf <= (take_in & cap.ovf) | (sticky_ovf & ~sticky_clr);
            case (state)
                EMPTY: if (take_in) begin
                    head  <= cap;
                    vld   <= 1'b1;
                    state <= ONE;
                end
                ONE: if (take_in && take_out) begin
                    head <= cap;
                end else if (take_in) begin
                    skid  <= cap;
                    rdy   <= 1'b0;
                    state <= TWO;
                end else if (take_out) begin
                    vld   <= 1'b0;
                    state <= EMPTY;
                end
                TWO: if (take_out) begin
                    head  <= skid;
                    rdy   <= 1'b1;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end
    assign alu.ready   = rdy;
    assign wb.valid    = vld;
    assign wb.result   = head.result;
    assign wb.zero     = head.zero;
    assign wb.overflow = head.ovf;
    assign wb.cout     = head.cout;
    assign wb.dest     = head.dest;
    assign wb.op       = 3'd0;
endmodule
